// File: rtl/pll_reset_sequencer.sv
// Power-up/run sequencer for the pixel-clock PLL, clocked entirely on refclk.
// Pulses the PLL reset, waits for lock with a timeout and bounded retries, and releases sys_rst_n once lock has held long enough.
module pll_reset_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [7:0] lol_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [1:0]       nxt_retry;
  logic [7:0]       nxt_lol;
  logic             sync1, lock_s;

  assign state_dbg = state;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      sync1     <= 1'b0;
      lock_s    <= 1'b0;
      retry_cnt <= 2'd0;
      lol_cnt   <= 8'd0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      sync1     <= pll_locked;
      lock_s    <= sync1;
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      retry_cnt <= nxt_retry;
      lol_cnt   <= nxt_lol;
      // Outputs decode the next state so they move on the same edge as the state register.
      pll_rst   <= (nxt_state == S_RESET_PLL) || (nxt_state == S_FAIL);
      sys_rst_n <= (nxt_state == S_RUN);
      ready     <= (nxt_state == S_RUN);
      fail      <= (nxt_state == S_FAIL);
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CNT_W'(1);
    nxt_retry = retry_cnt;
    nxt_lol   = lol_cnt;
    if (restart) begin
      nxt_state = S_RESET_PLL;
      nxt_cnt   = '0;
      nxt_retry = 2'd0;
    end else begin
      unique case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            nxt_state = S_WAIT_LOCK;
            nxt_cnt   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            nxt_state = S_STABLE;
            nxt_cnt   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            nxt_retry = retry_cnt + 2'd1;
            nxt_cnt   = '0;
            nxt_state = (nxt_retry == RETRY_MAX) ? S_FAIL : S_RESET_PLL;
          end
        end
        S_STABLE: begin
          // A single low lock sample discards the stable run; the timeout starts afresh.
          if (!lock_s) begin
            nxt_state = S_WAIT_LOCK;
            nxt_cnt   = '0;
          end else if (cnt == STABLE_LAST) begin
            nxt_state = S_RUN;
            nxt_cnt   = '0;
            nxt_retry = 2'd0;
          end
        end
        S_RUN: begin
          nxt_cnt = '0;
          if (!lock_s) begin
            nxt_state = S_RESET_PLL;
            if (lol_cnt != 8'hFF) nxt_lol = lol_cnt + 8'd1;
          end
        end
        S_FAIL: begin
          nxt_cnt = '0;
        end
        default: begin
          nxt_state = S_RESET_PLL;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scenario bench for pll_reset_sequencer with short counts (RST=4, TIMEOUT=32, STABLE=8, RETRIES=2).
// Expected snapshots and durations are queued when stimulus is applied and popped when the DUT responds.
module tb_pll_reset_sequencer;
  localparam int W = 17;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fail;
  logic [1:0] retry_cnt;
  logic [7:0] lol_cnt;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  int dur_q[$];

  pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(32), .LOCK_STABLE(8), .MAX_RETRIES(2), .CNT_W(17)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .restart(restart), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lol_cnt(lol_cnt), .state_dbg(state_dbg)
  );

  always #5 refclk = ~refclk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  function automatic logic [W-1:0] obs_now();
    return {state_dbg, pll_rst, sys_rst_n, ready, fail, retry_cnt, lol_cnt};
  endfunction

  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic pr, input logic sr,
                                      input logic rd, input logic fl, input logic [1:0] rc,
                                      input logic [7:0] lc);
    return {st, pr, sr, rd, fl, rc, lc};
  endfunction

  function automatic logic sig(input int which);
    case (which)
      0:       return pll_rst;
      1:       return sys_rst_n;
      2:       return ready;
      default: return (state_dbg == 3'd2);
    endcase
  endfunction

  // Bounded wait: cyc reaches limit if the level never shows up.
  task automatic wait_sig(input int which, input logic lvl, input int limit, output int cyc);
    cyc = 0;
    while (sig(which) !== lvl && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] got, exp;
    rst_n = 1'b0; restart = 1'b1; pll_locked = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0));
    tick(); tick(); tick();
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_state: got %h expected %h", got, exp); end
    restart = 1'b0; pll_locked = 1'b0;
    tick();
  endtask

  task automatic test_powerup();
    logic [W-1:0] got, exp;
    int c, d;
    rst_n = 1'b1;
    dur_q.push_back(4);
    wait_sig(0, 1'b0, 50, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL powerup_pll_rst_width: got %0d expected %0d", c, d); end
    exp_q.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0));
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL powerup_wait_lock: got %h expected %h", got, exp); end
    repeat (10) tick();
    pll_locked = 1'b1;
    dur_q.push_back(11);
    wait_sig(1, 1'b1, 100, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL powerup_lock_to_release: got %0d expected %0d", c, d); end
    exp_q.push_back(mk(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0));
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL powerup_run: got %h expected %h", got, exp); end
  endtask

  task automatic test_loss_of_lock();
    logic [W-1:0] got, exp;
    int c, d;
    pll_locked = 1'b0;
    dur_q.push_back(3);
    wait_sig(1, 1'b0, 20, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL lol_release_drop: got %0d expected %0d", c, d); end
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1));
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL lol_state: got %h expected %h", got, exp); end
    pll_locked = 1'b1;
    dur_q.push_back(4);
    dur_q.push_back(9);
    wait_sig(0, 1'b0, 50, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL lol_pll_rst_width: got %0d expected %0d", c, d); end
    wait_sig(1, 1'b1, 100, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL lol_resequence: got %0d expected %0d", c, d); end
    exp_q.push_back(mk(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1));
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL lol_run_again: got %h expected %h", got, exp); end
  endtask

  task automatic test_glitch();
    logic [W-1:0] got, exp;
    int c, d;
    restart = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1));
    tick();
    restart = 1'b0;
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch_restart_in_run: got %h expected %h", got, exp); end
    dur_q.push_back(5);
    wait_sig(3, 1'b1, 50, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL glitch_to_stable: got %0d expected %0d", c, d); end
    repeat (3) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    exp_q.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1));
    tick();
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL glitch_back_to_wait: got %h expected %h", got, exp); end
    dur_q.push_back(10);
    wait_sig(1, 1'b1, 50, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL glitch_release: got %0d expected %0d", c, d); end
  endtask

  task automatic test_fail();
    logic [W-1:0] got, exp;
    int c, d;
    pll_locked = 1'b0;
    restart = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1));
    tick();
    restart = 1'b0;
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fail_restart: got %h expected %h", got, exp); end
    for (int a = 1; a <= 2; a++) begin
      dur_q.push_back(4);
      dur_q.push_back(32);
      if (a == 1) exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd1));
      else        exp_q.push_back(mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd1));
      wait_sig(0, 1'b0, 50, c);
      d = dur_q.pop_front(); n_checks++;
      if (c !== d) begin n_fail++; $display("FAIL fail_pulse_width[%0d]: got %0d expected %0d", a, c, d); end
      wait_sig(0, 1'b1, 100, c);
      d = dur_q.pop_front(); n_checks++;
      if (c !== d) begin n_fail++; $display("FAIL fail_timeout[%0d]: got %0d expected %0d", a, c, d); end
      got = obs_now(); exp = exp_q.pop_front(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL fail_attempt[%0d]: got %h expected %h", a, got, exp); end
    end
    exp_q.push_back(mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd1));
    repeat (40) tick();
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fail_holds: got %h expected %h", got, exp); end
  endtask

  task automatic test_restart();
    logic [W-1:0] got, exp;
    int c, d;
    restart = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1));
    tick();
    restart = 1'b0;
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL restart_from_fail: got %h expected %h", got, exp); end
    dur_q.push_back(4);
    wait_sig(0, 1'b0, 50, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL restart_pll_rst_width: got %0d expected %0d", c, d); end
    pll_locked = 1'b1;
    tick(); tick();
    restart = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1));
    tick();
    restart = 1'b0;
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL restart_beats_lock: got %h expected %h", got, exp); end
    dur_q.push_back(13);
    wait_sig(2, 1'b1, 50, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL restart_to_run: got %0d expected %0d", c, d); end
  endtask

  task automatic test_rst_mid_wait();
    logic [W-1:0] got, exp;
    int c, d;
    pll_locked = 1'b0;
    dur_q.push_back(3);
    wait_sig(1, 1'b0, 20, c);
    d = dur_q.pop_front(); n_checks++;
    if (c !== d) begin n_fail++; $display("FAIL rstmid_release_drop: got %0d expected %0d", c, d); end
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2));
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rstmid_lol2: got %h expected %h", got, exp); end
    wait_sig(0, 1'b0, 20, c);
    repeat (5) tick();
    rst_n = 1'b0;
    restart = 1'b1;
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0));
    tick();
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rstmid_reset_wins: got %h expected %h", got, exp); end
    restart = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_lol_saturation();
    logic [W-1:0] got, exp;
    int c;
    exp_q.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd255));
    for (int i = 0; i < 256 + ($urandom_range(0, 3)); i++) begin
      pll_locked = 1'b1;
      wait_sig(2, 1'b1, 100, c);
      repeat ($urandom_range(0, 3)) tick();
      pll_locked = 1'b0;
      wait_sig(2, 1'b0, 20, c);
    end
    got = obs_now(); exp = exp_q.pop_front(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL lol_saturate: got %h expected %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_loss_of_lock();
    test_glitch();
    test_fail();
    test_restart();
    test_rst_mid_wait();
    test_lol_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
